// File: rtl/ctrl_pkg.sv
// Shared definitions for the fetch/decode sequencing controller: states, opcodes,
// register-write select encodings and the opcode decode helpers.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXEC    = 3'd3,
        ST_WB      = 3'd4,
        ST_STOPPED = 3'd5,
        ST_PAUSE   = 3'd6
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_MUL  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_MOVB = 4'h7;
    localparam logic [3:0] OP_STOP = 4'hF;

    localparam logic [1:0] WD_NONE = 2'b00;
    localparam logic [1:0] WD_A    = 2'b01;
    localparam logic [1:0] WD_B    = 2'b10;
    localparam logic [1:0] WD_A15  = 2'b11;

    function automatic logic [1:0] wd_decode(input logic [3:0] op);
        logic [1:0] wd;
        wd = WD_NONE;
        case (op)
            OP_ADD, OP_SUB, OP_MUL: wd = WD_A15;
            OP_AND, OP_OR, OP_LDI:  wd = WD_A;
            OP_MOVB:                wd = WD_B;
            default:                wd = WD_NONE;
        endcase
        return wd;
    endfunction

    function automatic logic op_known(input logic [3:0] op);
        return (op <= OP_MOVB) || (op == OP_STOP);
    endfunction

endpackage

// File: rtl/exec_counter.sv
// Loadable 4-bit down-counter with zero flag; sets the EXEC dwell time.
// Load takes priority over decrement; the count saturates at zero.
module exec_counter (
    input  logic       clk,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic [3:0] count,
    output logic       zero
);

    always_ff @(posedge clk) begin
        if (!clear) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/datapath_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer driving HALT, WRITEDST and ALUOP; all outputs registered.
// Optional CTRL_STEP_EN adds a STEP input and a PAUSE state after every writeback.
module datapath_ctrl
    import ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4
) (
    input  logic        CLOCK,
    input  logic        CLEAR,
    input  logic        RUN,
    input  logic [15:0] inst,
`ifdef CTRL_STEP_EN
    input  logic        STEP,
`endif
    output logic        HALT,
    output logic [1:0]  WRITEDST,
    output logic [3:0]  ALUOP,
    output logic        BUSY,
    output logic        ILLEGAL,
    output logic [15:0] RETIRED
);

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    state_t      state, next_state;
    logic [3:0]  opcode_q;
    logic [3:0]  op_cur;
    logic [3:0]  cnt;
    logic        cnt_zero;
    logic        halt_d;
    logic [1:0]  wd_d;
    logic [3:0]  aluop_d;
    logic        busy_d;
    logic        illegal_d;
    logic [15:0] retired_d;
    logic        unused_fields;

    assign unused_fields = ^{inst[11:0], cnt};

    // In DECODE the opcode register is only being written, so look through to inst.
    assign op_cur = (state == ST_DECODE) ? inst[15:12] : opcode_q;

    exec_counter u_exec_counter (
        .clk      (CLOCK),
        .clear    (CLEAR),
        .load     (state == ST_DECODE),
        .load_val ((inst[15:12] == OP_MUL) ? MUL_LOAD : 4'd0),
        .dec      (state == ST_EXEC),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge CLOCK) begin
        if (!CLEAR) begin
            state    <= ST_IDLE;
            opcode_q <= OP_NOP;
        end else begin
            state <= next_state;
            if (state == ST_DECODE) begin
                opcode_q <= inst[15:12];
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (RUN) next_state = ST_FETCH;
            ST_FETCH:   next_state = ST_DECODE;
            ST_DECODE:  next_state = (inst[15:12] == OP_STOP) ? ST_STOPPED : ST_EXEC;
            ST_EXEC:    if (cnt_zero) next_state = ST_WB;
`ifdef CTRL_STEP_EN
            ST_WB:      next_state = RUN ? ST_PAUSE : ST_IDLE;
            ST_PAUSE: begin
                if (!RUN)      next_state = ST_IDLE;
                else if (STEP) next_state = ST_FETCH;
            end
`else
            ST_WB:      next_state = RUN ? ST_FETCH : ST_IDLE;
`endif
            ST_STOPPED: next_state = ST_STOPPED;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Outputs are computed from the next state and registered alongside it.
    always_comb begin
        halt_d    = (next_state != ST_WB);
        wd_d      = (next_state == ST_WB) ? wd_decode(op_cur) : WD_NONE;
        aluop_d   = (next_state == ST_EXEC) ? op_cur : 4'd0;
        busy_d    = (next_state != ST_IDLE) && (next_state != ST_STOPPED);
        illegal_d = ILLEGAL || ((state == ST_DECODE) && !op_known(inst[15:12]));
        retired_d = RETIRED + ((next_state == ST_WB) ? 16'd1 : 16'd0);
    end

    always_ff @(posedge CLOCK) begin
        if (!CLEAR) begin
            HALT     <= 1'b1;
            WRITEDST <= WD_NONE;
            ALUOP    <= 4'd0;
            BUSY     <= 1'b0;
            ILLEGAL  <= 1'b0;
            RETIRED  <= 16'd0;
        end else begin
            HALT     <= halt_d;
            WRITEDST <= wd_d;
            ALUOP    <= aluop_d;
            BUSY     <= busy_d;
            ILLEGAL  <= illegal_d;
            RETIRED  <= retired_d;
        end
    end

endmodule
